// File: rtl/pga_autorange_pkg.sv
// pga_autorange_pkg: shared FSM states, gain codes, data widths and saturating |x| for the PGA autoranger.
package pga_autorange_pkg;
  typedef enum logic [1:0] {TRACK = 2'd0, SETTLE = 2'd1, MANUAL = 2'd2} state_e;
  localparam logic [1:0] GAIN_X1 = 2'd0;
  localparam logic [1:0] GAIN_X2 = 2'd1;
  localparam logic [1:0] GAIN_X4 = 2'd2;
  localparam logic [1:0] GAIN_X8 = 2'd3;
  localparam int ADC_W = 16;
  localparam int DATA_W = 19;
  // -32768 has no positive counterpart, so it saturates to 32767
  function automatic logic [ADC_W-1:0] sat_abs(input logic signed [ADC_W-1:0] x);
    return (x == {1'b1, {(ADC_W-1){1'b0}}}) ? {1'b0, {(ADC_W-1){1'b1}}} :
           x[ADC_W-1] ? ADC_W'(-x) : ADC_W'(x);
  endfunction
endpackage

// File: rtl/pga_autorange_if.sv
// pga_autorange_if: ADC sample, manual override and gain/data output bundle for both channels.
interface pga_autorange_if;
  import pga_autorange_pkg::*;
  logic signed [ADC_W-1:0] adc0_in, adc1_in;
  logic adc_valid_in;
  logic [1:0] manual_en_in, manual_gain0_in, manual_gain1_in;
  logic [1:0] gain0_out, gain1_out;
  logic signed [DATA_W-1:0] data0_out, data1_out;
  logic data_valid_out;
  logic [1:0] settling_out;
  modport master (
    output adc0_in, adc1_in, adc_valid_in, manual_en_in, manual_gain0_in, manual_gain1_in,
    input gain0_out, gain1_out, data0_out, data1_out, data_valid_out, settling_out
  );
  modport slave (
    input adc0_in, adc1_in, adc_valid_in, manual_en_in, manual_gain0_in, manual_gain1_in,
    output gain0_out, gain1_out, data0_out, data1_out, data_valid_out, settling_out
  );
endinterface

// File: rtl/pga_autorange_ch.sv
// pga_autorange_ch: one channel's peak detector, TRACK/SETTLE/MANUAL FSM and gain normaliser.
// With PGA_AUTORANGE_CLIP_EN defined, a single sample at or above CLIP_THRESH steps gain down at once.
module pga_autorange_ch
  import pga_autorange_pkg::*;
#(
  parameter logic [15:0] WIN_LEN = 16'd1024,
  parameter logic [15:0] HI_THRESH = 16'd24000,
  parameter logic [15:0] LO_THRESH = 16'd10000,
  parameter logic [15:0] SETTLE_CYC = 16'd200,
  parameter logic [1:0] MAX_GAIN = 2'd3
`ifdef PGA_AUTORANGE_CLIP_EN
  , parameter logic [15:0] CLIP_THRESH = 16'd32000
`endif
) (
  input logic clk_in,
  input logic rst_in,
  input logic signed [ADC_W-1:0] adc_in,
  input logic valid_in,
  input logic manual_en_in,
  input logic [1:0] manual_gain_in,
  output logic [1:0] gain_out,
  output logic signed [DATA_W-1:0] data_out,
  output logic valid_out,
  output logic settling_out
);
  state_e state_q;
  logic [1:0] gain_q;
  logic signed [DATA_W-1:0] data_q;
  logic valid_q;
  logic [15:0] peak_q, cnt_q, settle_q, msettle_q;
  logic [15:0] abs_x, pk;
  logic [1:0] man_g;
  logic win_end, clip, dn, up;
  assign abs_x = sat_abs(adc_in);
  assign pk = (abs_x > peak_q) ? abs_x : peak_q;
  assign man_g = (manual_gain_in > MAX_GAIN) ? MAX_GAIN : manual_gain_in;
  assign win_end = valid_in && (cnt_q == WIN_LEN - 16'd1);
`ifdef PGA_AUTORANGE_CLIP_EN
  assign clip = valid_in && (abs_x >= CLIP_THRESH) && (gain_q != GAIN_X1);
`else
  assign clip = 1'b0;
`endif
  // an overload clip replaces whatever the window end would have decided
  assign dn = clip || (win_end && (pk > HI_THRESH) && (gain_q != GAIN_X1));
  assign up = !clip && win_end && (pk < LO_THRESH) && (gain_q < MAX_GAIN);
  assign gain_out = gain_q;
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign settling_out = (state_q == SETTLE) || (msettle_q != 16'd0);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= TRACK;
      gain_q <= GAIN_X1;
      data_q <= '0;
      valid_q <= 1'b0;
      peak_q <= '0;
      cnt_q <= '0;
      settle_q <= '0;
      msettle_q <= '0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) data_q <= $signed({{(DATA_W-ADC_W){adc_in[ADC_W-1]}}, adc_in}) <<< (GAIN_X8 - gain_q);
      if (manual_en_in) begin
        state_q <= MANUAL;
        peak_q <= '0;
        cnt_q <= '0;
        if (man_g != gain_q) begin
          gain_q <= man_g;
          msettle_q <= SETTLE_CYC;
        end else if (msettle_q != 16'd0) msettle_q <= msettle_q - 16'd1;
      end else begin
        case (state_q)
          MANUAL: begin
            state_q <= SETTLE;
            settle_q <= SETTLE_CYC;
            msettle_q <= '0;
          end
          SETTLE: begin
            settle_q <= settle_q - 16'd1;
            if (settle_q == 16'd1) begin
              state_q <= TRACK;
              peak_q <= '0;
              cnt_q <= '0;
            end
          end
          default: if (valid_in) begin
            peak_q <= (clip || win_end) ? '0 : pk;
            cnt_q <= (clip || win_end) ? '0 : cnt_q + 16'd1;
            if (dn || up) begin
              gain_q <= dn ? gain_q - 2'd1 : gain_q + 2'd1;
              state_q <= SETTLE;
              settle_q <= SETTLE_CYC;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/pga_autorange.sv
// pga_autorange: dual-channel AD8251 gain autoranger; two independent channels sharing the ADC strobe.
// Define PGA_AUTORANGE_CLIP_EN to enable the immediate single-sample overload step-down.
module pga_autorange
  import pga_autorange_pkg::*;
#(
  parameter logic [15:0] WIN_LEN = 16'd1024,
  parameter logic [15:0] HI_THRESH = 16'd24000,
  parameter logic [15:0] LO_THRESH = 16'd10000,
  parameter logic [15:0] SETTLE_CYC = 16'd200,
  parameter logic [1:0] MAX_GAIN = 2'd3
`ifdef PGA_AUTORANGE_CLIP_EN
  , parameter logic [15:0] CLIP_THRESH = 16'd32000
`endif
) (
  input logic clk_in,
  input logic rst_in,
  pga_autorange_if.slave bus
);
  logic v0, v1, s0, s1;
  assign bus.data_valid_out = v0 & v1;
  assign bus.settling_out = {s1, s0};
  pga_autorange_ch #(
`ifdef PGA_AUTORANGE_CLIP_EN
    .CLIP_THRESH(CLIP_THRESH),
`endif
    .WIN_LEN(WIN_LEN), .HI_THRESH(HI_THRESH), .LO_THRESH(LO_THRESH),
    .SETTLE_CYC(SETTLE_CYC), .MAX_GAIN(MAX_GAIN)
  ) u_ch0 (
    .clk_in(clk_in), .rst_in(rst_in), .adc_in(bus.adc0_in), .valid_in(bus.adc_valid_in),
    .manual_en_in(bus.manual_en_in[0]), .manual_gain_in(bus.manual_gain0_in),
    .gain_out(bus.gain0_out), .data_out(bus.data0_out), .valid_out(v0), .settling_out(s0)
  );
  pga_autorange_ch #(
`ifdef PGA_AUTORANGE_CLIP_EN
    .CLIP_THRESH(CLIP_THRESH),
`endif
    .WIN_LEN(WIN_LEN), .HI_THRESH(HI_THRESH), .LO_THRESH(LO_THRESH),
    .SETTLE_CYC(SETTLE_CYC), .MAX_GAIN(MAX_GAIN)
  ) u_ch1 (
    .clk_in(clk_in), .rst_in(rst_in), .adc_in(bus.adc1_in), .valid_in(bus.adc_valid_in),
    .manual_en_in(bus.manual_en_in[1]), .manual_gain_in(bus.manual_gain1_in),
    .gain_out(bus.gain1_out), .data_out(bus.data1_out), .valid_out(v1), .settling_out(s1)
  );
endmodule

// File: tb/tb_pga_autorange.sv
// tb_pga_autorange: directed checks of windowed autoranging, hysteresis, manual override, data scaling and reset.
module tb_pga_autorange;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int n;
  pga_autorange_if b();
  pga_autorange dut (.clk_in(clk), .rst_in(rst), .bus(b));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic signed [15:0] a0, input logic signed [15:0] a1);
    b.adc0_in = a0;
    b.adc1_in = a1;
    b.adc_valid_in = 1'b1;
    @(posedge clk);
    #1;
    b.adc_valid_in = 1'b0;
  endtask

  task automatic window(input int cnt, input logic signed [15:0] a0, input logic signed [15:0] a1);
    repeat (cnt) sample(a0, a1);
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_settle(input int ch, output int cyc);
    cyc = 0;
    while (b.settling_out[ch] && cyc < 1000) begin
      cyc++;
      idle(1);
    end
  endtask

  initial begin
    b.adc0_in = '0;
    b.adc1_in = '0;
    b.adc_valid_in = 1'b0;
    b.manual_en_in = 2'b00;
    b.manual_gain0_in = 2'd0;
    b.manual_gain1_in = 2'd0;
    #12;
    chk("rst_gain0", b.gain0_out, 0);
    chk("rst_data0", b.data0_out, 0);
    chk("rst_valid", b.data_valid_out, 0);
    chk("rst_settling", b.settling_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // quiet windows step ch0 up to x8; ch1 sits between thresholds
    sample(-16'sd1234, 16'sd15000);
    chk("data_g0", b.data0_out, -9872);
    chk("valid_g0", b.data_valid_out, 1);
    window(1022, 16'sd500, 16'sd15000);
    chk("pre_win_gain0", b.gain0_out, 0);
    sample(16'sd500, 16'sd15000);
    chk("win1_gain0", b.gain0_out, 1);
    chk("win1_settling", b.settling_out, 1);
    wait_settle(0, n);
    chk("settle_len_auto", n, 200);
    window(1024, 16'sd500, 16'sd15000);
    chk("win2_gain0", b.gain0_out, 2);
    wait_settle(0, n);
    window(1024, 16'sd500, 16'sd15000);
    chk("win3_gain0", b.gain0_out, 3);
    wait_settle(0, n);
    window(1024, 16'sd500, 16'sd15000);
    chk("max_gain0", b.gain0_out, 3);
    chk("max_no_settle", b.settling_out, 0);
    chk("quiet_gain1", b.gain1_out, 0);

    // overload on the last sample of a window
    window(1023, 16'sd500, 16'sd15000);
    sample(-16'sd30000, 16'sd15000);
    chk("hi_gain0", b.gain0_out, 2);
    chk("hi_data_g3", b.data0_out, -30000);
    wait_settle(0, n);
    sample(16'sd1000, 16'sd500);
    chk("data_g2", b.data0_out, 2000);

    // hysteresis band on ch0 while ch1 steps up alone
    window(1023, 16'sd20000, 16'sd500);
    chk("hyst_gain0", b.gain0_out, 2);
    chk("hyst_gain1", b.gain1_out, 1);
    chk("hyst_settling", b.settling_out, 2);
    wait_settle(1, n);
    chk("settle_len_ch1", n, 200);

    // most negative sample saturates to 32767 and still steps down
    window(1023, 16'sd15000, 16'sd15000);
    sample(-16'sd32768, 16'sd15000);
    chk("neg_full_gain0", b.gain0_out, 1);
    chk("neg_full_data", b.data0_out, -65536);
    chk("neg_full_gain1", b.gain1_out, 1);
    wait_settle(0, n);
    sample(-16'sd1234, 16'sd15000);
    chk("data_g1", b.data0_out, -4936);
    chk("valid_hi", b.data_valid_out, 1);
    idle(1);
    chk("valid_lo", b.data_valid_out, 0);

    // manual override arrives on the window-end sample and wins
    window(1022, 16'sd500, 16'sd15000);
    b.manual_en_in = 2'b01;
    b.manual_gain0_in = 2'd3;
    sample(16'sd500, 16'sd15000);
    chk("man_gain0", b.gain0_out, 3);
    chk("man_settling", b.settling_out, 1);
    wait_settle(0, n);
    chk("man_pulse_len", n, 200);
    chk("man_hold_gain0", b.gain0_out, 3);
    b.manual_en_in = 2'b00;
    idle(1);
    chk("man_exit_settling", b.settling_out, 1);
    n = 0;
    while (b.settling_out[0] && n < 1000) begin
      n++;
      sample(16'sd30000, 16'sd15000);
    end
    chk("man_exit_len", n, 200);
    window(1024, 16'sd500, 16'sd15000);
    chk("post_man_gain0", b.gain0_out, 3);
    chk("post_man_settling", b.settling_out, 0);

    // asynchronous reset in the middle of a settle
    window(1023, 16'sd30000, 16'sd15000);
    sample(16'sd30000, 16'sd15000);
    chk("pre_rst_gain0", b.gain0_out, 2);
    idle(143);
    chk("pre_rst_settling", b.settling_out, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gain0", b.gain0_out, 0);
    chk("arst_gain1", b.gain1_out, 0);
    chk("arst_data0", b.data0_out, 0);
    chk("arst_settling", b.settling_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single near-full-scale sample at gain 2
    window(1024, 16'sd500, 16'sd15000);
    wait_settle(0, n);
    window(1024, 16'sd500, 16'sd15000);
    wait_settle(0, n);
    chk("clip_pre_gain0", b.gain0_out, 2);
    sample(16'sd32100, 16'sd15000);
`ifdef PGA_AUTORANGE_CLIP_EN
    chk("clip_gain0", b.gain0_out, 1);
    chk("clip_settling", b.settling_out, 1);
`else
    chk("noclip_gain0", b.gain0_out, 2);
    chk("noclip_settling", b.settling_out, 0);
`endif
    chk("clip_gain1", b.gain1_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
